// File: rtl/aes_shift_rows.sv
// AES-128 ShiftRows stage: fixed byte permutation into one 128-bit output register.
// Optional SHIFT_ROWS_INV_EN adds an `inverse` port that selects InvShiftRows.
module aes_shift_rows (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] state,
`ifdef SHIFT_ROWS_INV_EN
  input  logic         inverse,
`endif
  output logic [127:0] shifted_state
);

  logic [127:0] w_fwd;
`ifdef SHIFT_ROWS_INV_EN
  logic [127:0] w_inv;
`endif
  logic [127:0] w_next;
  logic [127:0] r_shifted;

  // Byte k = 4c+r sits at bits [127-8k -: 8]; row r rotates by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST     = 4 * c + r;
      localparam int SRC_FWD = 4 * ((c + r) % 4) + r;
      assign w_fwd[127-8*DST -: 8] = state[127-8*SRC_FWD -: 8];
`ifdef SHIFT_ROWS_INV_EN
      localparam int SRC_INV = 4 * ((c - r + 4) % 4) + r;
      assign w_inv[127-8*DST -: 8] = state[127-8*SRC_INV -: 8];
`endif
    end
  end

`ifdef SHIFT_ROWS_INV_EN
  assign w_next = inverse ? w_inv : w_fwd;
`else
  assign w_next = w_fwd;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shifted <= 128'h0;
    end else begin
      r_shifted <= w_next;
    end
  end

  assign shifted_state = r_shifted;

endmodule

// File: tb/tb_aes_shift_rows.sv
// Self-checking bench for aes_shift_rows; exercises InvShiftRows when SHIFT_ROWS_INV_EN is defined.
module tb_aes_shift_rows;

  logic         clk;
  logic         rst;
  logic [127:0] state;
  logic [127:0] shifted_state;
`ifdef SHIFT_ROWS_INV_EN
  logic         inverse;
`endif

  int total = 0;
  int bad   = 0;

  aes_shift_rows dut (
    .clk          (clk),
    .rst          (rst),
    .state        (state),
`ifdef SHIFT_ROWS_INV_EN
    .inverse      (inverse),
`endif
    .shifted_state(shifted_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: unpack into a 4x4 matrix, rotate each row one step at a time r times.
  function automatic logic [127:0] ref_model(input logic [127:0] s, input bit inv);
    logic [7:0] m [4][4];
    logic [7:0] t;
    logic [127:0] o;
    for (int k = 0; k < 16; k++) m[k % 4][k / 4] = s[127-8*k -: 8];
    for (int r = 1; r < 4; r++) begin
      for (int n = 0; n < r; n++) begin
        if (!inv) begin
          t = m[r][0];
          m[r][0] = m[r][1]; m[r][1] = m[r][2]; m[r][2] = m[r][3]; m[r][3] = t;
        end else begin
          t = m[r][3];
          m[r][3] = m[r][2]; m[r][2] = m[r][1]; m[r][1] = m[r][0]; m[r][0] = t;
        end
      end
    end
    o = '0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = m[k % 4][k / 4];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    logic [127:0] s;
    rst   = 1'b1;
    state = rand128();
    #1;
    total++;
    if (shifted_state !== 128'h0) begin
      bad++; $display("FAIL reset_initial got=%h exp=0", shifted_state);
    end
    rst = 1'b0;
    @(negedge clk);
    s = rand128(); state = s;
    @(negedge clk);
    total++;
    if (shifted_state !== ref_model(s, 1'b0)) begin
      bad++; $display("FAIL pre_reset_load got=%h exp=%h", shifted_state, ref_model(s, 1'b0));
    end
    // async assertion mid-cycle, away from any edge
    #2 rst = 1'b1;
    #1;
    total++;
    if (shifted_state !== 128'h0) begin
      bad++; $display("FAIL reset_async got=%h exp=0", shifted_state);
    end
    for (int i = 0; i < 3; i++) begin
      state = rand128();
      @(negedge clk);
      total++;
      if (shifted_state !== 128'h0) begin
        bad++; $display("FAIL reset_hold cyc=%0d got=%h exp=0", i, shifted_state);
      end
    end
    s = rand128(); state = s; rst = 1'b0;
    @(negedge clk);
    total++;
    if (shifted_state !== ref_model(s, 1'b0)) begin
      bad++; $display("FAIL reset_release got=%h exp=%h", shifted_state, ref_model(s, 1'b0));
    end
  endtask

  task automatic test_vectors();
    state = 128'h00112233445566778899aabbccddeeff;
    @(negedge clk);
    total++;
    if (shifted_state !== 128'h0055aaff4499ee3388dd2277cc1166bb) begin
      bad++; $display("FAIL counting got=%h exp=0055aaff4499ee3388dd2277cc1166bb", shifted_state);
    end
    state = 128'hd4e0b81e27bfb44111985d52aef1e530;
    @(negedge clk);
    total++;
    if (shifted_state !== 128'hd4bf5d302798e51e11f1b841aee0b452) begin
      bad++; $display("FAIL fips got=%h exp=d4bf5d302798e51e11f1b841aee0b452", shifted_state);
    end
    // held input keeps output constant
    @(negedge clk);
    total++;
    if (shifted_state !== 128'hd4bf5d302798e51e11f1b841aee0b452) begin
      bad++; $display("FAIL hold got=%h exp=d4bf5d302798e51e11f1b841aee0b452", shifted_state);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] vin [2];
    logic [127:0] vexp [2];
    vin[0]  = 128'h00112233445566778899aabbccddeeff;
    vin[1]  = 128'hd4e0b81e27bfb44111985d52aef1e530;
    vexp[0] = 128'h0055aaff4499ee3388dd2277cc1166bb;
    vexp[1] = 128'hd4bf5d302798e51e11f1b841aee0b452;
    state = vin[0];
    @(negedge clk);
    state = vin[1];
    total++;
    if (shifted_state !== vexp[0]) begin
      bad++; $display("FAIL b2b_first got=%h exp=%h", shifted_state, vexp[0]);
    end
    @(negedge clk);
    state = vin[0];
    total++;
    if (shifted_state !== vexp[1]) begin
      bad++; $display("FAIL b2b_second got=%h exp=%h", shifted_state, vexp[1]);
    end
    @(negedge clk);
    total++;
    if (shifted_state !== vexp[0]) begin
      bad++; $display("FAIL b2b_third got=%h exp=%h", shifted_state, vexp[0]);
    end
  endtask

  task automatic test_walking();
    logic [127:0] s;
    logic [127:0] e;
    for (int k = 0; k < 16; k++) begin
      s = '0;
      s[127-8*k -: 8] = 8'hff;
      state = s;
      @(negedge clk);
      e = ref_model(s, 1'b0);
      total++;
      if (shifted_state !== e) begin
        bad++; $display("FAIL walk k=%0d got=%h exp=%h", k, shifted_state, e);
      end
    end
  endtask

  task automatic test_random_stream();
    logic [127:0] e;
    state = rand128();
    e = ref_model(state, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      total++;
      if (shifted_state !== e) begin
        bad++; $display("FAIL rand i=%0d got=%h exp=%h", i, shifted_state, e);
      end
      state = rand128();
      e = ref_model(state, 1'b0);
    end
  endtask

`ifdef SHIFT_ROWS_INV_EN
  task automatic test_inverse();
    logic [127:0] e;
    bit           m;
    inverse = 1'b1;
    state   = 128'hd4bf5d302798e51e11f1b841aee0b452;
    @(negedge clk);
    total++;
    if (shifted_state !== 128'hd4e0b81e27bfb44111985d52aef1e530) begin
      bad++; $display("FAIL inv_fips got=%h exp=d4e0b81e27bfb44111985d52aef1e530", shifted_state);
    end
    m = 1'b0;
    inverse = m;
    state = rand128();
    e = ref_model(state, m);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      total++;
      if (shifted_state !== e) begin
        bad++; $display("FAIL inv_toggle i=%0d mode=%0d got=%h exp=%h", i, m, shifted_state, e);
      end
      m = ~m;
      inverse = m;
      state = rand128();
      e = ref_model(state, m);
    end
    inverse = 1'b0;
  endtask
`endif

  initial begin
`ifdef SHIFT_ROWS_INV_EN
    inverse = 1'b0;
`endif
    rst   = 1'b1;
    state = '0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_walking();
    test_random_stream();
`ifdef SHIFT_ROWS_INV_EN
    test_inverse();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
